// File: rtl/btn_input_unit_pkg.sv
// ----------------------------------------------------------------------------
// btn_input_unit_pkg
// Shared definitions for the button peripheral and the bus bridge that decodes
// it: base address, register offsets, default sizing and the register-select
// encoding used on btn_addr[2].
// No ports (package).
// ----------------------------------------------------------------------------
package btn_input_unit_pkg;

    // Base address of the button peripheral on the SoC I/O bus.
    localparam logic [31:0] BTN_BASE_ADDR        = 32'h1000_0000;

    // Register offsets within the peripheral window.
    localparam logic [31:0] BTN_LEVEL_OFFSET     = 32'h0000_0000;
    localparam logic [31:0] BTN_EVENT_OFFSET     = 32'h0000_0004;

    // Default sizing.
    localparam int unsigned BTN_NUM_DEFAULT      = 32'd5;
    localparam int unsigned BTN_DEBOUNCE_DEFAULT = 32'd20000;

    // The bridge compares the address bits under this mask against
    // BTN_BASE_ADDR; bit 2 is left for the peripheral's register select.
    localparam logic [31:0] BTN_DECODE_MASK      = 32'hFFFF_FFF8;

    // Register select carried on btn_addr[2].
    typedef enum logic {
        BTN_REG_LEVEL = 1'b0,
        BTN_REG_EVENT = 1'b1
    } btn_reg_e;

    // Bridge-side decode of the button window.
    function automatic logic btn_addr_hit(input logic [31:0] addr);
        return ((addr & BTN_DECODE_MASK) == BTN_BASE_ADDR);
    endfunction

endpackage

// File: rtl/btn_input_unit_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One button channel: a 2-flop synchroniser followed by a saturating run-length
// counter. The stable level follows the synchronised input only after it has
// disagreed with the stable level for DEBOUNCE_CYCLES consecutive clocks; any
// return to the stable value restarts the run from zero.
// Ports:
//   clk     - sole clock
//   rst_n   - synchronous active-low reset (clears all state)
//   button  - raw asynchronous input, active-high
//   stable  - debounced level (registered)
// ----------------------------------------------------------------------------
module btn_debounce
    import btn_input_unit_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic stable
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             meta_r;
    logic             sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             stable_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Run-length count of disagreement; commit the new level at the terminal count.
    always_comb begin
        stable_next_s = stable_r;
        cnt_next_s    = {CNT_W{1'b0}};
        if (sync_r != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                stable_next_s = sync_r;
                cnt_next_s    = {CNT_W{1'b0}};
            end else begin
                cnt_next_s    = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = {CNT_W{1'b0}};
        end
    end

    // Synchroniser chain, counter and stable level registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else begin
            meta_r   <= button;
            sync_r   <= meta_r;
            cnt_r    <= cnt_next_s;
            stable_r <= stable_next_s;
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/btn_input_unit.sv
// ----------------------------------------------------------------------------
// btn_input_unit
// Memory-mapped button peripheral. Debounces NUM_BTN raw buttons, latches
// rising edges of the debounced levels into sticky event flags, and exposes
// either the levels (addr[2]=0) or the flags (addr[2]=1) as read data.
// Flags are cleared by a write-1-to-clear store to the EVENT register; on a
// simultaneous set and clear of the same bit the set wins.
// Ports:
//   btn_clk           - sole clock
//   btn_rst           - synchronous active-low reset
//   btn_addr          - bus address; only bit 2 is decoded here
//   btn_we            - write strobe, already qualified by the bridge decode
//   btn_wdata         - write data; [NUM_BTN-1:0] is the clear mask
//   button            - raw asynchronous buttons, active-high
//   rdata_btn2bridge  - read data, combinational from registers
//   btn_event_any     - OR of all event flags
// ----------------------------------------------------------------------------
module btn_input_unit
    import btn_input_unit_pkg::*;
#(
    parameter int unsigned NUM_BTN         = BTN_NUM_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT
) (
    input  logic               btn_clk,
    input  logic               btn_rst,
    input  logic [31:0]        btn_addr,
    input  logic               btn_we,
    input  logic [31:0]        btn_wdata,
    input  logic [NUM_BTN-1:0] button,
    output logic [31:0]        rdata_btn2bridge,
    output logic               btn_event_any
);

    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] prev_r;
    logic [NUM_BTN-1:0] event_r;
    logic [NUM_BTN-1:0] event_next_s;
    logic [NUM_BTN-1:0] rise_s;
    logic [NUM_BTN-1:0] clr_s;
    logic [31:0]        rdata_s;
    btn_reg_e           reg_sel_s;
    logic               unused_bits_s;

    assign reg_sel_s = btn_reg_e'(btn_addr[2]);

    // Address and data bits outside the decoded field are deliberately ignored.
    assign unused_bits_s = &{1'b0, btn_addr[31:3], btn_addr[1:0], btn_wdata[31:NUM_BTN]};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (btn_clk),
            .rst_n  (btn_rst),
            .button (button[i]),
            .stable (level_s[i])
        );
    end

    // Rising-edge detect and W1C flag update; set is ORed in last so it wins.
    always_comb begin
        rise_s = level_s & ~prev_r;
        if (btn_we && (reg_sel_s == BTN_REG_EVENT)) begin
            clr_s = btn_wdata[NUM_BTN-1:0];
        end else begin
            clr_s = {NUM_BTN{1'b0}};
        end
        event_next_s = (event_r & ~clr_s) | rise_s;
    end

    // Previous-level and sticky event flag registers.
    always_ff @(posedge btn_clk) begin
        if (!btn_rst) begin
            prev_r  <= {NUM_BTN{1'b0}};
            event_r <= {NUM_BTN{1'b0}};
        end else begin
            prev_r  <= level_s;
            event_r <= event_next_s;
        end
    end

    // Zero-latency read mux; the bridge samples read data asynchronously.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (reg_sel_s)
            BTN_REG_LEVEL: rdata_s[NUM_BTN-1:0] = level_s;
            BTN_REG_EVENT: rdata_s[NUM_BTN-1:0] = event_r;
            default:       rdata_s = 32'h0000_0000;
        endcase
    end

    assign rdata_btn2bridge = rdata_s;
    assign btn_event_any    = |event_r;

endmodule

// File: tb/tb_btn_input_unit.sv
// ----------------------------------------------------------------------------
// tb_btn_input_unit
// Scoreboard bench: each stimulus cycle pushes the expected read data and
// event-any value (from a behavioural model, optionally plus a hand-derived
// constant) into a queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_btn_input_unit;
    import btn_input_unit_pkg::*;

    localparam int NB = 5;
    localparam int DC = 4;

    localparam logic [31:0] A_LVL = BTN_BASE_ADDR | BTN_LEVEL_OFFSET;
    localparam logic [31:0] A_EVT = BTN_BASE_ADDR | BTN_EVENT_OFFSET;

    logic          btn_clk;
    logic          btn_rst;
    logic [31:0]   btn_addr;
    logic          btn_we;
    logic [31:0]   btn_wdata;
    logic [NB-1:0] button;
    logic [31:0]   rdata_btn2bridge;
    logic          btn_event_any;

    btn_input_unit #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .btn_clk          (btn_clk),
        .btn_rst          (btn_rst),
        .btn_addr         (btn_addr),
        .btn_we           (btn_we),
        .btn_wdata        (btn_wdata),
        .button           (button),
        .rdata_btn2bridge (rdata_btn2bridge),
        .btn_event_any    (btn_event_any)
    );

    initial btn_clk = 1'b0;
    // Free-running 10 ns clock.
    always #5 btn_clk = ~btn_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        any;
        bit          has_c;
        logic [31:0] c_rdata;
        logic        c_any;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: raw samples delayed two clocks, and per bit the number
    // of consecutive clocks the delayed input has disagreed with the level.
    logic [NB-1:0] m_lvl;
    logic [NB-1:0] m_prev;
    logic [NB-1:0] m_ev;
    logic [NB-1:0] m_hist[$];
    int            m_run[NB];

    task automatic model_reset();
        m_lvl  = '0;
        m_prev = '0;
        m_ev   = '0;
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
        for (int i = 0; i < NB; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [NB-1:0] seen;
        logic [NB-1:0] clr;
        logic [NB-1:0] rise;
        if (!btn_rst) begin
            model_reset();
        end else begin
            seen = m_hist[0];
            clr  = (btn_we && btn_addr[2]) ? btn_wdata[NB-1:0] : '0;
            rise = m_lvl & ~m_prev;
            m_ev   = (m_ev & ~clr) | rise;
            m_prev = m_lvl;
            for (int i = 0; i < NB; i++) begin
                if (seen[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DC) begin
                        m_lvl[i] = seen[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_hist.push_back(button);
            void'(m_hist.pop_front());
        end
    endtask

    // One bus cycle with the currently driven inputs.
    task automatic step(input string name = "", input bit has_c = 1'b0,
                        input logic [31:0] c_rdata = 32'h0, input logic c_any = 1'b0);
        exp_t e;
        e.rdata         = 32'h0;
        e.rdata[NB-1:0] = btn_addr[2] ? m_ev : m_lvl;
        e.any           = |m_ev;
        e.has_c         = has_c;
        e.c_rdata       = c_rdata;
        e.c_any         = c_any;
        e.name          = (name == "") ? "model" : name;
        sb_q.push_back(e);
        @(posedge btn_clk);
        model_edge();
        #1;
    endtask

    // Monitor: compare the DUT's outputs mid-cycle against the queued expectation.
    always @(negedge btn_clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (rdata_btn2bridge !== e.rdata) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", e.name, rdata_btn2bridge, e.rdata);
            end
            checks++;
            if (btn_event_any !== e.any) begin
                errors++;
                $display("FAIL %s event_any: got %b expected %b", e.name, btn_event_any, e.any);
            end
            if (e.has_c) begin
                checks++;
                if (rdata_btn2bridge !== e.c_rdata) begin
                    errors++;
                    $display("FAIL %s rdata_const: got %h expected %h", e.name, rdata_btn2bridge, e.c_rdata);
                end
                checks++;
                if (btn_event_any !== e.c_any) begin
                    errors++;
                    $display("FAIL %s any_const: got %b expected %b", e.name, btn_event_any, e.c_any);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        btn_rst   = 1'b0;
        button    = 5'h1F;
        btn_addr  = A_LVL;
        btn_we    = 1'b0;
        btn_wdata = 32'h0;
        @(posedge btn_clk);
        model_reset();
        #1;
        step();
        step();

        // Reset release with all buttons held.
        btn_rst = 1'b1;
        step("rst_lvl", 1'b1, 32'h0, 1'b0);
        btn_addr = A_EVT;
        step("rst_evt", 1'b1, 32'h0, 1'b0);
        btn_addr = A_LVL;
        repeat (3) step();
        step("lvl_pre", 1'b1, 32'h0, 1'b0);
        step("lvl_6", 1'b1, 32'h1F, 1'b0);
        btn_addr = A_EVT;
        step("evt_7", 1'b1, 32'h1F, 1'b1);

        // Release everything and clear all flags.
        button = 5'h00;
        repeat (8) step();
        btn_we = 1'b1; btn_wdata = 32'h1F;
        step();
        btn_we = 1'b0;
        step("clr_all", 1'b1, 32'h0, 1'b0);

        // Bounce rejection on button[0].
        btn_addr = A_LVL;
        for (int k = 0; k < 2; k++) begin
            button[0] = 1'b1;
            repeat (2) step("bounce", 1'b1, 32'h0, 1'b0);
            button[0] = 1'b0;
            repeat (2) step("bounce", 1'b1, 32'h0, 1'b0);
        end
        button[0] = 1'b1;
        repeat (6) step("hold_pre", 1'b1, 32'h0, 1'b0);
        step("hold_6", 1'b1, 32'h1, 1'b0);
        btn_addr = A_EVT;
        step("bounce_evt", 1'b1, 32'h1, 1'b1);

        // W1C on flags 0x03.
        button[1] = 1'b1;
        repeat (8) step();
        step("w1c_pre", 1'b1, 32'h3, 1'b1);
        btn_we = 1'b1; btn_wdata = 32'h2;
        step("w1c_same", 1'b1, 32'h3, 1'b1);
        btn_we = 1'b0;
        step("w1c_a", 1'b1, 32'h1, 1'b1);
        btn_we = 1'b1; btn_wdata = 32'h1;
        step();
        btn_we = 1'b0;
        step("w1c_b", 1'b1, 32'h0, 1'b0);

        // Clear of bit 4 on the same edge as its rise: set wins.
        button[4] = 1'b1;
        repeat (6) step("sbc_pre", 1'b1, 32'h0, 1'b0);
        btn_we = 1'b1; btn_wdata = 32'h10;
        step("sbc_edge", 1'b1, 32'h0, 1'b0);
        btn_we = 1'b0;
        step("sbc_set", 1'b1, 32'h10, 1'b1);

        // Release of button[0] creates no flag; LEVEL ignores writes.
        button[0] = 1'b0;
        btn_addr  = A_LVL;
        repeat (6) step("rel_pre", 1'b1, 32'h13, 1'b1);
        step("rel_6", 1'b1, 32'h12, 1'b1);
        btn_addr = A_EVT;
        step("rel_evt", 1'b1, 32'h10, 1'b1);
        btn_addr = A_LVL; btn_we = 1'b1; btn_wdata = 32'hFFFF_FFFF;
        step("wlvl", 1'b1, 32'h12, 1'b1);
        btn_we = 1'b0;
        step("wlvl_l", 1'b1, 32'h12, 1'b1);
        btn_addr = A_EVT;
        step("wlvl_e", 1'b1, 32'h10, 1'b1);

        // Reset while button[2]'s count is at 2.
        button[2] = 1'b1;
        btn_addr  = A_LVL;
        repeat (4) step();
        btn_rst = 1'b0;
        step();
        btn_rst = 1'b1;
        repeat (6) step("rmid_pre", 1'b1, 32'h0, 1'b0);
        step("rmid_6", 1'b1, 32'h16, 1'b0);
        btn_addr = A_EVT;
        step("rmid_evt", 1'b1, 32'h16, 1'b1);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(5, 0) == 0) button[$urandom_range(NB - 1, 0)] ^= 1'b1;
            btn_addr  = $urandom();
            btn_we    = ($urandom_range(9, 0) == 0);
            btn_wdata = $urandom();
            btn_rst   = ($urandom_range(99, 0) != 0);
            step();
        end
        btn_rst = 1'b1;
        btn_we  = 1'b0;
        repeat (2) step();

        @(negedge btn_clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_input_unit.md
Name: btn_input_unit

Overview:
- Memory-mapped button peripheral on the SoC I/O bus, directly upstream of the bus bridge's button read port.
- Synchronises and debounces the 5 raw board buttons. Records rising-edge press events in sticky flags.
- Returns either the debounced levels or the event flags to the CPU as 32-bit read data. Event flags are cleared by a write-1-to-clear store.

Parameters:
- NUM_BTN, 5, number of button inputs (1..16).
- DEBOUNCE_CYCLES, 20000, consecutive stable clocks required before a debounced level changes (>=2).

Ports:
- btn_clk  in  1  bridge-supplied CPU clock; the only clock.
- btn_rst  in  1  reset, synchronous, active-low.
- btn_addr  in  32  bus address from bridge; only bit 2 is decoded.
- btn_we  in  1  write strobe from bridge, already qualified by the bridge's address decode.
- btn_wdata  in  32  write data; bits [NUM_BTN-1:0] are the clear mask.
- button  in  NUM_BTN  raw asynchronous board buttons, active-high.
- rdata_btn2bridge  out  32  read data to bridge.
- btn_event_any  out  1  OR of all sticky event flags.

Behaviour:
- Reset: on any btn_clk rising edge with btn_rst=0, the following all go to 0 on that edge:
  - synchroniser flops
  - debounce counters
  - debounced levels
  - previous-level register
  - event flags
- Consequences of reset:
  - btn_event_any=0 and rdata_btn2bridge=0 from the first cycle after the reset edge.
  - A reset in the middle of debouncing discards the partial count.
- Synchroniser: a 2-flop chain per bit, so raw-to-sync latency is 2 clocks. No logic reads the raw input directly.
- Debounce, per bit:
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If sync != stable, the counter increments. Otherwise the counter clears to 0.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != stable, on that edge: stable <= sync and counter <= 0.
  - Any glitch back to the stable value before the terminal count restarts the count from 0.
  - Counter never wraps past DEBOUNCE_CYCLES-1.
  - Total latency from a raw change to a stable change is 2 + DEBOUNCE_CYCLES clocks.
- Edge detect: prev <= stable every cycle. rise = stable & ~prev. Release edges are ignored.
- Event flags: next = (event & ~clr) | rise, where clr = btn_we ? btn_wdata[NUM_BTN-1:0] : 0.
  - When a set and a clear hit the same bit in the same cycle, set wins.
  - Writing 0 bits leaves those flags unchanged.
- Register map, selected by btn_addr[2]:
  - 0 = LEVEL: bits [NUM_BTN-1:0] = debounced levels; writes are ignored.
  - 1 = EVENT: bits [NUM_BTN-1:0] = sticky flags; writes are W1C.
  - Upper bits always read 0.
- Read path: combinational from registers to rdata_btn2bridge, with zero-cycle latency, matching the bridge's asynchronous read timing.
- Writes take effect at the clock edge on which btn_we=1. A read in the same cycle returns the pre-write value.
- btn_event_any is a combinational OR of the flag registers. It is glitch-free because all its inputs are registered.
- No state machine beyond the per-bit counters. The block has no back-pressure and no stalls.

Decomposition:
- Shared defines header holds:
  - BTN base address
  - LEVEL/EVENT offsets (0x0, 0x4)
  - NUM_BTN default
  - the bridge decode constant
- The bridge decode for the button base address lives in the bridge, not in this block.
- One sub-module, btn_debounce: a 1-bit synchroniser plus counter plus stable level, with parameter DEBOUNCE_CYCLES. The top instantiates NUM_BTN copies via a generate loop and adds the edge/event/bus logic.

Test Plan:
- Reset and idle. DEBOUNCE_CYCLES=4; hold btn_rst=0 for 3 clocks with button=5'b11111, then release. Required: LEVEL reads 0 and EVENT reads 0 at release. LEVEL reads 0x1F exactly 2+4 clocks after release, and EVENT reads 0x1F one clock after that.
- Bounce rejection. Starting from button[0]=0, toggle button[0] 1,0,1,0 every 2 clocks, then hold at 1. Required: LEVEL[0] stays 0 throughout the toggling. LEVEL[0]=1 exactly 6 clocks after the final rising transition. EVENT = 0x01 and btn_event_any=1.
- W1C. With EVENT=0x03, write wdata=0x00000002 at offset 0x4. Required: EVENT=0x01 next cycle and btn_event_any stays 1. Then write 0x1 and require EVENT=0, btn_event_any=0.
- Set beats clear. Schedule a write of clr=0x10 on the same edge as button[4]'s debounced rise. Required: EVENT[4]=1 after that edge.
- Release and write-ignore. Release button[0] after debounce. Required: LEVEL[0]=0 after 6 clocks with no new EVENT bit. A write of 0xFFFFFFFF to offset 0x0 changes nothing. Bits [31:5] read 0 at both offsets.
- Reset mid-debounce. Raise button[2], assert btn_rst=0 for 1 clock at counter=2, then deassert. Required: LEVEL[2]=1 only 2+4 clocks after the deassert, and EVENT[2] sets then.
